// File: rtl/move_commit.sv
// move_commit: legality check and commit for a proposed piece position.
// Walks the four rows of the piece's 4x4 mask (read strobe, then compare),
// accumulating a collision flag against walls, floor and occupied cells.
// A clean proposal is committed into cur_*; a rejected fall raises lock.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid_i/req_ready_o    proposal handshake (req_fall_i, test_*_i payload)
//   shape_type_o/shape_mask_i  shape ROM lookup (latched type -> 4x4 mask)
//   row_rd_o/row_addr_o        board row read, row_data_i valid one cycle later
//   spawn_i/spawn_type_i       load a new piece, overrides everything
//   cur_type_o/cur_x_o/cur_y_o committed piece state
//   done_o/accepted_o/lock_o   one-cycle result strobes
module move_commit #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 20,
    parameter int unsigned SPAWN_X = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_fall_i,
    input  logic [4:0]         test_type_i,
    input  logic [3:0]         test_x_i,
    input  logic [4:0]         test_y_i,
    output logic [4:0]         shape_type_o,
    input  logic [15:0]        shape_mask_i,
    output logic               row_rd_o,
    output logic [4:0]         row_addr_o,
    input  logic [BOARD_W-1:0] row_data_i,
    input  logic               spawn_i,
    input  logic [4:0]         spawn_type_i,
    output logic [4:0]         cur_type_o,
    output logic [3:0]         cur_x_o,
    output logic [4:0]         cur_y_o,
    output logic               done_o,
    output logic               accepted_o,
    output logic               lock_o
);

    localparam int unsigned TYPE_W = 5;
    localparam int unsigned X_W    = 4;
    localparam int unsigned Y_W    = 5;
    localparam int unsigned ST_W   = 4;

    // Sequential encoding: each RD/CMP step advances by one.
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RD0    = 4'd1;
    localparam logic [3:0] S_CMP0   = 4'd2;
    localparam logic [3:0] S_RD1    = 4'd3;
    localparam logic [3:0] S_CMP1   = 4'd4;
    localparam logic [3:0] S_RD2    = 4'd5;
    localparam logic [3:0] S_CMP2   = 4'd6;
    localparam logic [3:0] S_RD3    = 4'd7;
    localparam logic [3:0] S_CMP3   = 4'd8;
    localparam logic [3:0] S_RESULT = 4'd9;

    logic [ST_W-1:0]   st_q, st_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              fall_q, fall_d;
    logic              coll_q, coll_d;
    logic [TYPE_W-1:0] cur_type_q, cur_type_d;
    logic [X_W-1:0]    cur_x_q, cur_x_d;
    logic [Y_W-1:0]    cur_y_q, cur_y_d;
    logic              done_q, done_d;
    logic              acc_q, acc_d;
    logic              lock_q, lock_d;
    logic [Y_W-1:0]    addr_q, addr_d;

    logic              is_rd, is_cmp;
    logic [1:0]        r;
    logic [3:0]        nib;
    logic [5:0]        row_sum;
    logic              row_oob;
    logic [4:0]        col;
    logic [15:0]       row_pad;
    logic              hit;

    // Current mask row index and step type from the state.
    always_comb begin
        is_rd  = 1'b0;
        is_cmp = 1'b0;
        r      = 2'd0;
        case (st_q)
            S_RD0:   begin is_rd  = 1'b1; r = 2'd0; end
            S_CMP0:  begin is_cmp = 1'b1; r = 2'd0; end
            S_RD1:   begin is_rd  = 1'b1; r = 2'd1; end
            S_CMP1:  begin is_cmp = 1'b1; r = 2'd1; end
            S_RD2:   begin is_rd  = 1'b1; r = 2'd2; end
            S_CMP2:  begin is_cmp = 1'b1; r = 2'd2; end
            S_RD3:   begin is_rd  = 1'b1; r = 2'd3; end
            S_CMP3:  begin is_cmp = 1'b1; r = 2'd3; end
            default: ;
        endcase
    end

    assign nib     = shape_mask_i[{r, 2'b00} +: 4];
    assign row_sum = 6'(y_q) + 6'(r);
    assign row_oob = row_sum >= 6'(BOARD_H);
    assign row_pad = 16'(row_data_i);

    // Collision for this mask row; a set bit below the floor or past the
    // right wall collides without consulting the board.
    always_comb begin
        hit = 1'b0;
        col = 5'd0;
        for (int unsigned c = 0; c < 4; c++) begin
            col = 5'(x_q) + 5'(c);
            if (nib[2'(c)]) begin
                if (row_oob || col >= 5'(BOARD_W)) begin
                    hit = 1'b1;
                end else if (row_pad[col[3:0]]) begin
                    hit = 1'b1;
                end
            end
        end
    end

    // Next-state and output decode; spawn overrides every state.
    always_comb begin
        st_d       = st_q;
        type_d     = type_q;
        x_d        = x_q;
        y_d        = y_q;
        fall_d     = fall_q;
        coll_d     = coll_q;
        cur_type_d = cur_type_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        done_d     = 1'b0;
        acc_d      = 1'b0;
        lock_d     = 1'b0;
        addr_d     = addr_q;
        if (spawn_i) begin
            st_d       = S_IDLE;
            cur_type_d = spawn_type_i;
            cur_x_d    = X_W'(SPAWN_X);
            cur_y_d    = '0;
        end else begin
            case (st_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        type_d = test_type_i;
                        x_d    = test_x_i;
                        y_d    = test_y_i;
                        fall_d = req_fall_i;
                        coll_d = 1'b0;
                        addr_d = test_y_i;
                        st_d   = S_RD0;
                    end
                end
                S_RESULT: begin
                    if (!coll_q) begin
                        cur_type_d = type_q;
                        cur_x_d    = x_q;
                        cur_y_d    = y_q;
                    end
                    st_d = S_IDLE;
                end
                default: begin
                    if (is_rd) begin
                        st_d = ST_W'(st_q + 4'd1);
                    end else if (is_cmp) begin
                        coll_d = coll_q | hit;
                        st_d   = ST_W'(st_q + 4'd1);
                        if (r != 2'd3) begin
                            addr_d = Y_W'(y_q + 5'(r) + 5'd1);
                        end else begin
                            done_d = 1'b1;
                            acc_d  = ~(coll_q | hit);
                            lock_d = (coll_q | hit) & fall_q;
                        end
                    end else begin
                        st_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= S_IDLE;
            type_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            fall_q     <= 1'b0;
            coll_q     <= 1'b0;
            cur_type_q <= '0;
            cur_x_q    <= X_W'(SPAWN_X);
            cur_y_q    <= '0;
            done_q     <= 1'b0;
            acc_q      <= 1'b0;
            lock_q     <= 1'b0;
            addr_q     <= '0;
        end else begin
            st_q       <= st_d;
            type_q     <= type_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fall_q     <= fall_d;
            coll_q     <= coll_d;
            cur_type_q <= cur_type_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            done_q     <= done_d;
            acc_q      <= acc_d;
            lock_q     <= lock_d;
            addr_q     <= addr_d;
        end
    end

    // Ready and read strobe must react within the cycle they are needed.
    assign req_ready_o  = (st_q == S_IDLE) & ~spawn_i;
    assign row_rd_o     = is_rd & (nib != 4'd0) & ~row_oob;
    assign row_addr_o   = addr_q;
    assign shape_type_o = type_q;
    assign cur_type_o   = cur_type_q;
    assign cur_x_o      = cur_x_q;
    assign cur_y_o      = cur_y_q;
    assign done_o       = done_q;
    assign accepted_o   = acc_q;
    assign lock_o       = lock_q;

endmodule

// File: tb/tb_move_commit.sv
// Directed testbench for move_commit: board RAM and shape ROM models,
// one task per scenario with inline expected-value comparisons.
module tb_move_commit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_fall;
    logic [4:0]  test_type;
    logic [3:0]  test_x;
    logic [4:0]  test_y;
    logic [4:0]  shape_type;
    logic [15:0] shape_mask;
    logic        row_rd;
    logic [4:0]  row_addr;
    logic [9:0]  row_data;
    logic        spawn;
    logic [4:0]  spawn_type;
    logic [4:0]  cur_type;
    logic [3:0]  cur_x;
    logic [4:0]  cur_y;
    logic        done;
    logic        accepted;
    logic        lock;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [9:0] board [0:31];
    logic [4:0] rd_log [0:15];
    int         rd_total = 0;

    int         dc, dn, lc, rc;
    logic       ac, lk, r9, r10;
    logic [4:0] a0, a1;

    move_commit #(.BOARD_W(10), .BOARD_H(20), .SPAWN_X(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_fall_i   (req_fall),
        .test_type_i  (test_type),
        .test_x_i     (test_x),
        .test_y_i     (test_y),
        .shape_type_o (shape_type),
        .shape_mask_i (shape_mask),
        .row_rd_o     (row_rd),
        .row_addr_o   (row_addr),
        .row_data_i   (row_data),
        .spawn_i      (spawn),
        .spawn_type_i (spawn_type),
        .cur_type_o   (cur_type),
        .cur_x_o      (cur_x),
        .cur_y_o      (cur_y),
        .done_o       (done),
        .accepted_o   (accepted),
        .lock_o       (lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shape ROM: type 0 = O piece, type 4 = horizontal I piece.
    function automatic logic [15:0] rom(input logic [4:0] t);
        case (t)
            5'b00000: rom = 16'h0660;
            5'b00100: rom = 16'h00F0;
            default:  rom = 16'h0000;
        endcase
    endfunction
    assign shape_mask = rom(shape_type);

    // Board RAM with one-cycle read latency; logs every read address.
    always @(posedge clk) begin
        if (row_rd) begin
            row_data <= board[row_addr];
            rd_log[4'(rd_total)] <= row_addr;
            rd_total <= rd_total + 1;
        end
    end

    task automatic run_check(
        input  logic [4:0] t, input logic [3:0] x, input logic [4:0] y, input logic f,
        input  int spawn_at, input logic [4:0] sp_t,
        output int done_cyc, output int done_cnt, output int lock_cnt,
        output logic acc, output logic lk_at, output int rd_cnt,
        output logic [4:0] rd_a0, output logic [4:0] rd_a1,
        output logic rdy9, output logic rdy10);
        int rd0;
        done_cyc = 0; done_cnt = 0; lock_cnt = 0; acc = 1'b0; lk_at = 1'b0;
        rdy9 = 1'b0; rdy10 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_fall = f; test_type = t; test_x = x; test_y = y;
        rd0 = rd_total;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin done_cyc = n; acc = accepted; lk_at = lock; end
            end
            if (lock) lock_cnt++;
            if (n == 9)  rdy9  = req_ready;
            if (n == 10) rdy10 = req_ready;
            if (n == spawn_at) begin spawn = 1'b1; spawn_type = sp_t; end
            else spawn = 1'b0;
        end
        rd_cnt = rd_total - rd0;
        rd_a0  = rd_log[4'(rd0)];
        rd_a1  = rd_log[4'(rd0 + 1)];
    endtask

    task automatic test_reset;
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %0b expected 1", req_ready); end
        tests_run++; if ({done, accepted, lock, row_rd} !== 4'b0000) begin tests_failed++; $display("FAIL rst_strobes: got %b expected 0000", {done, accepted, lock, row_rd}); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd0, 4'd3, 5'd0}) begin tests_failed++; $display("FAIL rst_cur: got %0d/%0d/%0d expected 0/3/0", cur_type, cur_x, cur_y); end
        tests_run++; if ({row_addr, shape_type} !== 10'd0) begin tests_failed++; $display("FAIL rst_addr_type: got %0d/%0d expected 0/0", row_addr, shape_type); end
    endtask

    task automatic test_empty_o;
        run_check(5'b00000, 4'd4, 5'd3, 1'b0, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if (dc !== 9) begin tests_failed++; $display("FAIL o_done_cycle: got %0d expected 9", dc); end
        tests_run++; if (dn !== 1) begin tests_failed++; $display("FAIL o_done_count: got %0d expected 1", dn); end
        tests_run++; if (ac !== 1'b1) begin tests_failed++; $display("FAIL o_accepted: got %0b expected 1", ac); end
        tests_run++; if (lc !== 0) begin tests_failed++; $display("FAIL o_lock: got %0d expected 0", lc); end
        tests_run++; if (rc !== 2) begin tests_failed++; $display("FAIL o_row_reads: got %0d expected 2", rc); end
        tests_run++; if ({a0, a1} !== {5'd4, 5'd5}) begin tests_failed++; $display("FAIL o_row_addrs: got %0d,%0d expected 4,5", a0, a1); end
        tests_run++; if ({r9, r10} !== 2'b01) begin tests_failed++; $display("FAIL o_ready_timing: got %b expected 01", {r9, r10}); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd0, 4'd4, 5'd3}) begin tests_failed++; $display("FAIL o_cur: got %0d/%0d/%0d expected 0/4/3", cur_type, cur_x, cur_y); end
    endtask

    task automatic test_walls;
        run_check(5'b00100, 4'd7, 5'd3, 1'b0, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if ({dc, dn} !== {32'd9, 32'd1}) begin tests_failed++; $display("FAIL wall7_done: got %0d/%0d expected 9/1", dc, dn); end
        tests_run++; if ({ac, lc} !== {1'b0, 32'd0}) begin tests_failed++; $display("FAIL wall7_reject: got acc=%0b lock=%0d expected 0/0", ac, lc); end
        tests_run++; if (shape_type !== 5'd4) begin tests_failed++; $display("FAIL wall7_shape_type: got %0d expected 4", shape_type); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd0, 4'd4, 5'd3}) begin tests_failed++; $display("FAIL wall7_cur: got %0d/%0d/%0d expected 0/4/3", cur_type, cur_x, cur_y); end
        run_check(5'b00100, 4'd15, 5'd3, 1'b0, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if ({dn, ac} !== {32'd1, 1'b0}) begin tests_failed++; $display("FAIL wall15_reject: got done=%0d acc=%0b expected 1/0", dn, ac); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd0, 4'd4, 5'd3}) begin tests_failed++; $display("FAIL wall15_cur: got %0d/%0d/%0d expected 0/4/3", cur_type, cur_x, cur_y); end
        run_check(5'b00100, 4'd6, 5'd3, 1'b0, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if ({dn, ac, rc} !== {32'd1, 1'b1, 32'd1}) begin tests_failed++; $display("FAIL wall6_accept: got done=%0d acc=%0b reads=%0d expected 1/1/1", dn, ac, rc); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd4, 4'd6, 5'd3}) begin tests_failed++; $display("FAIL wall6_cur: got %0d/%0d/%0d expected 4/6/3", cur_type, cur_x, cur_y); end
    endtask

    task automatic test_floor;
        run_check(5'b00100, 4'd3, 5'd19, 1'b1, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if (rc !== 0) begin tests_failed++; $display("FAIL floor_row_reads: got %0d expected 0", rc); end
        tests_run++; if ({dc, ac} !== {32'd9, 1'b0}) begin tests_failed++; $display("FAIL floor_reject: got cyc=%0d acc=%0b expected 9/0", dc, ac); end
        tests_run++; if ({lc, lk} !== {32'd1, 1'b1}) begin tests_failed++; $display("FAIL floor_lock: got count=%0d at_done=%0b expected 1/1", lc, lk); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd4, 4'd6, 5'd3}) begin tests_failed++; $display("FAIL floor_cur: got %0d/%0d/%0d expected 4/6/3", cur_type, cur_x, cur_y); end
        run_check(5'b00100, 4'd3, 5'd18, 1'b1, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if ({ac, lc, rc} !== {1'b1, 32'd0, 32'd1}) begin tests_failed++; $display("FAIL floor18_accept: got acc=%0b lock=%0d reads=%0d expected 1/0/1", ac, lc, rc); end
        tests_run++; if (a0 !== 5'd19) begin tests_failed++; $display("FAIL floor18_addr: got %0d expected 19", a0); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd4, 4'd3, 5'd18}) begin tests_failed++; $display("FAIL floor18_cur: got %0d/%0d/%0d expected 4/3/18", cur_type, cur_x, cur_y); end
    endtask

    task automatic test_board_hit;
        board[5] = 10'b0000010000;
        run_check(5'b00000, 4'd3, 5'd4, 1'b1, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if ({dn, ac, lc} !== {32'd1, 1'b0, 32'd1}) begin tests_failed++; $display("FAIL hit_reject: got done=%0d acc=%0b lock=%0d expected 1/0/1", dn, ac, lc); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd4, 4'd3, 5'd18}) begin tests_failed++; $display("FAIL hit_cur: got %0d/%0d/%0d expected 4/3/18", cur_type, cur_x, cur_y); end
        run_check(5'b00000, 4'd5, 5'd4, 1'b0, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if (ac !== 1'b1) begin tests_failed++; $display("FAIL hit_miss_accept: got %0b expected 1", ac); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd0, 4'd5, 5'd4}) begin tests_failed++; $display("FAIL hit_miss_cur: got %0d/%0d/%0d expected 0/5/4", cur_type, cur_x, cur_y); end
        board[5] = 10'b0;
        run_check(5'b00000, 4'd3, 5'd4, 1'b0, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if ({dn, ac} !== {32'd1, 1'b1}) begin tests_failed++; $display("FAIL empty_accept: got done=%0d acc=%0b expected 1/1", dn, ac); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd0, 4'd3, 5'd4}) begin tests_failed++; $display("FAIL empty_cur: got %0d/%0d/%0d expected 0/3/4", cur_type, cur_x, cur_y); end
    endtask

    task automatic test_reset_mid;
        int dcount;
        dcount = 0;
        @(negedge clk);
        req_valid = 1'b1; req_fall = 1'b0; test_type = 5'b00000; test_x = 4'd6; test_y = 5'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++; if ({cur_x, cur_y} !== {4'd3, 5'd0}) begin tests_failed++; $display("FAIL rstmid_cur: got %0d/%0d expected 3/0", cur_x, cur_y); end
        tests_run++; if ({req_ready, done, row_rd, shape_type} !== {3'b100, 5'd0}) begin tests_failed++; $display("FAIL rstmid_ctrl: got rdy=%0b done=%0b rd=%0b type=%0d expected 1/0/0/0", req_ready, done, row_rd, shape_type); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        tests_run++; if (dcount !== 0) begin tests_failed++; $display("FAIL rstmid_no_done: got %0d expected 0", dcount); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd0, 4'd3, 5'd0}) begin tests_failed++; $display("FAIL rstmid_cur_after: got %0d/%0d/%0d expected 0/3/0", cur_type, cur_x, cur_y); end
    endtask

    task automatic test_spawn;
        int dcount;
        run_check(5'b00000, 4'd6, 5'd2, 1'b0, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if ({cur_x, cur_y} !== {4'd6, 5'd2}) begin tests_failed++; $display("FAIL spawn_pre_cur: got %0d/%0d expected 6/2", cur_x, cur_y); end
        run_check(5'b00000, 4'd4, 5'd0, 1'b1, 4, 5'b01010, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if ({dn, lc} !== {32'd0, 32'd0}) begin tests_failed++; $display("FAIL spawn_abort: got done=%0d lock=%0d expected 0/0", dn, lc); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd10, 4'd3, 5'd0}) begin tests_failed++; $display("FAIL spawn_cur: got %0d/%0d/%0d expected 10/3/0", cur_type, cur_x, cur_y); end
        tests_run++; if (r10 !== 1'b1) begin tests_failed++; $display("FAIL spawn_idle_ready: got %0b expected 1", r10); end
        dcount = 0;
        @(negedge clk);
        spawn = 1'b1; spawn_type = 5'b10011;
        req_valid = 1'b1; test_type = 5'b00000; test_x = 4'd7; test_y = 5'd7; req_fall = 1'b0;
        #1;
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL spawn_req_ready: got %0b expected 0", req_ready); end
        @(posedge clk);
        #1 spawn = 1'b0; req_valid = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        tests_run++; if (dcount !== 0) begin tests_failed++; $display("FAIL spawn_req_not_taken: got %0d dones expected 0", dcount); end
        tests_run++; if ({cur_type, cur_x, cur_y, req_ready} !== {5'd19, 4'd3, 5'd0, 1'b1}) begin tests_failed++; $display("FAIL spawn_req_cur: got %0d/%0d/%0d rdy=%0b expected 19/3/0/1", cur_type, cur_x, cur_y, req_ready); end
    endtask

    task automatic test_back_to_back;
        run_check(5'b00100, 4'd0, 5'd0, 1'b0, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if ({dc, ac, rc} !== {32'd9, 1'b1, 32'd1}) begin tests_failed++; $display("FAIL b2b_first: got cyc=%0d acc=%0b reads=%0d expected 9/1/1", dc, ac, rc); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd4, 4'd0, 5'd0}) begin tests_failed++; $display("FAIL b2b_first_cur: got %0d/%0d/%0d expected 4/0/0", cur_type, cur_x, cur_y); end
        run_check(5'b00000, 4'd8, 5'd10, 1'b0, 0, 5'd0, dc, dn, lc, ac, lk, rc, a0, a1, r9, r10);
        tests_run++; if ({dc, ac, lc} !== {32'd9, 1'b0, 32'd0}) begin tests_failed++; $display("FAIL b2b_second: got cyc=%0d acc=%0b lock=%0d expected 9/0/0", dc, ac, lc); end
        tests_run++; if ({a0, a1} !== {5'd11, 5'd12}) begin tests_failed++; $display("FAIL b2b_second_addrs: got %0d,%0d expected 11,12", a0, a1); end
        tests_run++; if ({cur_type, cur_x, cur_y} !== {5'd4, 4'd0, 5'd0}) begin tests_failed++; $display("FAIL b2b_second_cur: got %0d/%0d/%0d expected 4/0/0", cur_type, cur_x, cur_y); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) board[i] = 10'b0;
        for (int i = 0; i < 16; i++) rd_log[i] = 5'd0;
        row_data   = 10'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_fall   = 1'b0;
        test_type  = 5'd0;
        test_x     = 4'd0;
        test_y     = 5'd0;
        spawn      = 1'b0;
        spawn_type = 5'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_empty_o();
        test_walls();
        test_floor();
        test_board_hit();
        test_reset_mid();
        test_spawn();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
